// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op and state encodings plus op-decode helpers for the mul/div sequencer
package muldiv_pkg;
  typedef enum logic [2:0] {
    MUL = 3'd0, MULH = 3'd1, MULHU = 3'd3, DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7
  } op_t;
  typedef enum logic [1:0] {IDLE, BUSY, FIN, DONE} state_t;
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction
  function automatic logic is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction
  function automatic logic is_hi(input logic [2:0] op);
    return ~op[2] & op[0];
  endfunction
  function automatic logic is_signed(input logic [2:0] op);
    return (op == MULH) | (op == DIV) | (op == REM);
  endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add (multiply) or shift-subtract-restore (divide) iteration
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] hi_nx,
  output logic [XLEN-1:0] lo_nx
);
  logic [XLEN:0]   sum, sh;
  logic [XLEN-1:0] diff;
  logic            ge;
  always_comb begin
    sum   = {1'b0, hi} + {1'b0, d & {XLEN{lo[0]}}};
    sh    = {hi, lo[XLEN-1]};
    ge    = sh >= {1'b0, d};
    diff  = sh[XLEN-1:0] - d;
    hi_nx = div ? (ge ? diff : sh[XLEN-1:0]) : sum[XLEN:1];
    lo_nx = div ? {lo[XLEN-2:0], ge} : {sum[0], lo[XLEN-1:1]};
  end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative M-extension multiply/divide sequencer with pipeline stall request
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  state_t            state, state_nx;
  logic [2:0]        op_q;
  logic              sa, sb, sa_in, sb_in, go, special;
  logic [XLEN-1:0]   hi, lo, d, hi_nx, lo_nx, spec_res, q, r, fin_res;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [CW-1:0]     cnt;
  muldiv_step #(.XLEN(XLEN)) u_step (
    .div(is_div(op_q)), .hi(hi), .lo(lo), .d(d), .hi_nx(hi_nx), .lo_nx(lo_nx)
  );
  // Operands are latched as magnitudes; the signs are reapplied in FIN.
  always_comb begin
    go       = start & ~flush;
    sa_in    = is_signed(op) & a[XLEN-1];
    sb_in    = is_signed(op) & b[XLEN-1];
    special  = is_div(op) ? (b == '0) | (is_signed(op) & (a == MIN) & (b == '1))
                          : (a == '0) | (b == '0);
    spec_res = is_div(op) ? ((b == '0) ? (is_rem(op) ? a : '1) : (is_rem(op) ? '0 : a)) : '0;
    prod     = {hi, lo};
    prod_s   = (sa ^ sb) ? -prod : prod;
    q        = (sa ^ sb) ? -lo : lo;
    r        = sa ? -hi : hi;
    fin_res  = is_div(op_q) ? (is_rem(op_q) ? r : q)
                            : (is_hi(op_q) ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0]);
  end
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = go ? (special ? DONE : BUSY) : IDLE;
      BUSY:    state_nx = flush ? IDLE : ((cnt == CW'(1)) ? FIN : BUSY);
      FIN:     state_nx = flush ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      d      <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && go) begin
        op_q <= op;
        sa   <= sa_in;
        sb   <= sb_in;
        hi   <= '0;
        lo   <= sa_in ? -a : a;
        d    <= sb_in ? -b : b;
        cnt  <= CW'(XLEN);
        if (special) result <= spec_res;
      end
      if (state == BUSY) begin
        hi  <= hi_nx;
        lo  <= lo_nx;
        cnt <= cnt - CW'(1);
      end
      if (state == FIN && !flush) result <= fin_res;
    end
  end
  assign stall = (state == IDLE & go) | (state == BUSY) | (state == FIN);
  assign busy  = state != IDLE;
  assign done  = state == DONE;
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer for the EX stage.
- Takes the M-extension ops (MUL, MULH, MULHU, DIV, DIVU, REM, REMU) off the single-cycle ALU.
- Runs one shift-add or shift-subtract step per cycle and holds the pipeline with a stall request.
- Returns a result the writeback mux can select.
- The control unit raises start for M-type decodes; stall feeds the same path as the existing stall_EX/stall_FETCH.

Parameters:
- XLEN, 32, operand/result width; step counter width is clog2(XLEN)+1.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  3  operation; encoding in muldiv_pkg
- a  in  XLEN  rs1 operand, sampled with start
- b  in  XLEN  rs2 operand, sampled with start
- flush  in  1  abort an in-flight op (branch/jal redirect)
- stall  out  1  hold fetch/EX while the op is outstanding
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, result valid
- result  out  XLEN  registered result; held until the next done

Behaviour:
- Reset values:
  - State IDLE.
  - stall, busy, done = 0.
  - result = 0.
  - Counter and internal accumulators = 0.
- States and transitions:
  - IDLE: start=1 latches op, a, b and the operand signs.
    - Special case (see below): go to DONE.
    - Otherwise: go to BUSY with count = XLEN.
  - BUSY: one iteration per cycle, count decrements; at count==1 go to FIN.
  - FIN: apply sign correction and high/low select, register result, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Latency:
  - start accepted in cycle N; done in cycle N+XLEN+2 (N+34 for XLEN=32).
  - Special cases: done in cycle N+1.
- stall:
  - stall = (IDLE & start & ~flush) | BUSY | FIN. It is combinational on start so the requesting instruction holds in its start cycle.
  - stall = 0 in DONE so the instruction retires that cycle with result valid.
- Multiply:
  - Unsigned shift-add on operand magnitudes into a 2*XLEN product.
  - MULH: magnitudes of both signed operands; negate the product if the signs differ; return the upper XLEN bits.
  - MULHU: unsigned, upper half.
  - MUL: lower half; sign is irrelevant.
- Divide:
  - Restoring shift-subtract on magnitudes.
  - DIV/REM: the quotient is negated if the signs differ; the remainder takes the dividend's sign.
  - DIVU/REMU: unsigned.
- Special cases, resolved in IDLE without iterating:
  - b==0: DIV/DIVU give all-ones; REM/REMU give a.
  - Signed overflow (a = most-negative, b = -1): DIV gives a, REM gives 0.
  - Either operand 0 on a multiply: 0.
- flush:
  - In BUSY/FIN: go to IDLE next cycle, no done, result unchanged.
  - In IDLE with start: start is ignored.
  - In DONE: no effect; the pulse still occurs.
- start while not IDLE is ignored; there is no queueing.
- rst mid-operation: all state returns to reset values on the next edge; no done.
- Undefined op codes: treated as MUL.

Decomposition:
- muldiv_pkg holds:
  - op enum: MUL=0, MULH=1, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
  - State enum {IDLE, BUSY, FIN, DONE}.
  - Helper function is_div(op).
- One natural sub-module, muldiv_step: the combinational single-iteration datapath (add-or-not / subtract-and-restore, shift). The sequencer owns the state, counter, sign fix and result register.

Test Plan:
- MUL a=7, b=6, start at N -> stall high N..N+33; done=1 and result=42 at N+34; stall=0 at N+34.
- MULH a=0xFFFFFFFF (-1), b=0x00000002 -> result 0xFFFFFFFF; MULHU with the same operands -> result 0x00000001.
- DIV a=-7, b=2 -> result 0xFFFFFFFD (-3); REM with the same operands -> 0xFFFFFFFF (-1); DIVU a=100, b=7 -> 14.
- DIVU a=5, b=0 -> done at N+1, result 0xFFFFFFFF; REM a=0x80000000, b=-1 -> done at N+1, result 0.
- DIV start, flush at N+10 -> IDLE at N+11; no done pulse; result keeps its previous value; a new start at N+12 completes normally.
- rst asserted at N+5 of a MUL -> busy/stall/done = 0 after the edge, result = 0; start asserted in BUSY is ignored (exactly one done pulse).
